// File: rtl/host_rsp_encode_arbiter.sv
// host_rsp_encode_arbiter
// Round-robin arbiter that shares one host UART response encoder between
// NUM_REQ command handlers. For each grant it issues the encoder start, then
// follows the encoder's done handshake: done drops when the encoder accepts
// the job and rises when it finishes. Each wait phase has a timeout. The
// finished frame and an error/timeout status go back to the granted
// requester with a one-cycle ack pulse.
module host_rsp_encode_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 264,
  parameter int FRAME_W        = 1025,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [16*NUM_REQ-1:0]     req_cmd_select,
  input  logic [NUM_REQ-1:0]        req_status,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [FRAME_W-1:0]        rsp_frame,
  output logic                      rsp_error,
  output logic                      rsp_timeout,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic                      enc_start,
  output logic [15:0]               enc_cmd_select,
  output logic                      enc_status,
  output logic [DATA_W-1:0]         enc_data,
  input  logic [FRAME_W-1:0]        enc_frame,
  input  logic                      enc_done,
  input  logic                      enc_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_e;

  state_e               state_q;
  logic [2:0]           rr_ptr_q;
  logic [2:0]           grant_id_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic [FRAME_W-1:0]   rsp_frame_q;
  logic                 rsp_error_q;
  logic                 rsp_timeout_q;
  logic                 enc_start_q;
  logic [15:0]          enc_cmd_q;
  logic                 enc_status_q;
  logic [DATA_W-1:0]    enc_data_q;

  logic                 grant_vld_d;
  logic [2:0]           grant_idx_d;
  logic [15:0]          sel_cmd_d;
  logic                 sel_status_d;
  logic [DATA_W-1:0]    sel_data_d;
  logic                 timeout_hit;
  logic [NUM_REQ-1:0]   ack_onehot;

  assign timeout_hit = (cnt_q == CNT_LAST);
  assign ack_onehot  = NUM_REQ'(1) << grant_id_q;

  // Pick the first pending requester after rr_ptr (wrapping) and mux its payload.
  always_comb begin
    grant_vld_d  = 1'b0;
    grant_idx_d  = '0;
    sel_cmd_d    = req_cmd_select[15:0];
    sel_status_d = req_status[0];
    sel_data_d   = req_data[DATA_W-1:0];
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_vld_d && req[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant_vld_d = 1'b1;
        grant_idx_d = 3'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_d == 3'(i)) begin
        sel_cmd_d    = req_cmd_select[16*i +: 16];
        sel_status_d = req_status[i];
        sel_data_d   = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // Transaction FSM: grant, start pulse, done-drop/done-rise handshake with timeout, ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= 3'(NUM_REQ - 1);
      grant_id_q    <= '0;
      cnt_q         <= '0;
      ack_q         <= '0;
      rsp_frame_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      enc_start_q   <= 1'b0;
      enc_cmd_q     <= '0;
      enc_status_q  <= 1'b0;
      enc_data_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q <= '0;
          // An encoder that is not idle may be serving another master; wait.
          if (grant_vld_d && enc_done) begin
            grant_id_q   <= grant_idx_d;
            enc_cmd_q    <= sel_cmd_d;
            enc_status_q <= sel_status_d;
            enc_data_q   <= sel_data_d;
            enc_start_q  <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          enc_start_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!enc_done) begin
            cnt_q   <= '0;
            state_q <= S_WAIT_DONE;
          end else if (timeout_hit) begin
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            ack_q         <= ack_onehot;
            state_q       <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (enc_done) begin
            rsp_frame_q   <= enc_frame;
            rsp_error_q   <= enc_error;
            rsp_timeout_q <= 1'b0;
            ack_q         <= ack_onehot;
            state_q       <= S_RESP;
          end else if (timeout_hit) begin
            // Frame is left untouched: the encoder never delivered one.
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            ack_q         <= ack_onehot;
            state_q       <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          ack_q       <= '0;
          enc_start_q <= 1'b0;
          rr_ptr_q    <= grant_id_q;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack            = ack_q;
  assign rsp_frame      = rsp_frame_q;
  assign rsp_error      = rsp_error_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign grant_id       = grant_id_q;
  assign busy           = (state_q != S_IDLE);
  assign enc_start      = enc_start_q;
  assign enc_cmd_select = enc_cmd_q;
  assign enc_status     = enc_status_q;
  assign enc_data       = enc_data_q;

endmodule

// File: tb/tb_host_rsp_encode_arbiter.sv
// Testbench for host_rsp_encode_arbiter with a behavioural response encoder.
module tb_host_rsp_encode_arbiter;

  localparam int N  = 4;
  localparam int DW = 264;
  localparam int FW = 1025;
  localparam int T  = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]      req;
  logic [16*N-1:0]   req_cmd_select;
  logic [N-1:0]      req_status;
  logic [DW*N-1:0]   req_data;
  logic [N-1:0]      ack;
  logic [FW-1:0]     rsp_frame;
  logic              rsp_error;
  logic              rsp_timeout;
  logic [2:0]        grant_id;
  logic              busy;
  logic              enc_start;
  logic [15:0]       enc_cmd_select;
  logic              enc_status;
  logic [DW-1:0]     enc_data;
  logic [FW-1:0]     enc_frame = '0;
  logic              enc_done  = 1'b1;
  logic              enc_error = 1'b0;

  host_rsp_encode_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .FRAME_W(FW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_cmd_select(req_cmd_select),
    .req_status(req_status), .req_data(req_data), .ack(ack),
    .rsp_frame(rsp_frame), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .grant_id(grant_id), .busy(busy), .enc_start(enc_start),
    .enc_cmd_select(enc_cmd_select), .enc_status(enc_status),
    .enc_data(enc_data), .enc_frame(enc_frame), .enc_done(enc_done),
    .enc_error(enc_error)
  );

  int n_vec = 0;
  int n_err = 0;

  // Encoder model controls: mode 0 normal, 1 never drops done, 2 never raises done.
  int mode = 0;
  int k_lat = 3;
  int m_cnt = 0;
  int idle_req = 0;
  int idle_seen = 0;

  // Observations collected by run_one
  logic [N-1:0] obs_ack;
  int obs_scyc, obs_lat, obs_starts;

  function automatic logic bad_cmd(input logic [15:0] c);
    return (c == 16'h0000) || (c > 16'h0010);
  endfunction

  function automatic logic [FW-1:0] exp_frame(input logic [15:0] c, input logic s,
                                              input logic [DW-1:0] d);
    logic [FW-1:0] f;
    f = '0;
    f[7:0]     = s ? 8'h02 : 8'h03;
    f[23:8]    = c;
    f[24 +: DW] = d;
    f[FW-1]    = ^d;
    return f;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [287:0] t;
    for (int w = 0; w < 9; w++) t[w*32 +: 32] = $urandom();
    return t[DW-1:0];
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Behavioural encoder: done drops on start, rises k_lat cycles later with the frame.
  always @(negedge clk) begin
    if (idle_req != idle_seen) begin
      idle_seen = idle_req;
      enc_done  = 1'b1;
    end else if (enc_start) begin
      if (mode != 1) begin
        enc_done = 1'b0;
        m_cnt    = k_lat;
      end
    end else if (!enc_done && mode == 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        enc_done  = 1'b1;
        enc_frame = exp_frame(enc_cmd_select, enc_status, enc_data);
        enc_error = bad_cmd(enc_cmd_select);
      end
    end
  end

  task automatic set_slot(input int idx, input logic [15:0] c, input logic s,
                          input logic [DW-1:0] d);
    req_cmd_select[16*idx +: 16] = c;
    req_status[idx]              = s;
    req_data[DW*idx +: DW]       = d;
  endtask

  // Raise one request and wait (bounded) for its ack; called at a negedge.
  task automatic run_one(input int idx, input logic [15:0] c, input logic s,
                         input logic [DW-1:0] d);
    set_slot(idx, c, s, d);
    req[idx] = 1'b1;
    obs_ack = '0; obs_scyc = -1000; obs_lat = -1; obs_starts = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (enc_start) begin
        obs_starts++;
        obs_scyc = i;
      end
      if (|ack) begin
        obs_ack = ack;
        obs_lat = i - obs_scyc;
        break;
      end
    end
    req[idx] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (ack !== '0) begin n_err++; $display("FAIL reset_ack got %b want 0", ack); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (enc_start !== 1'b0) begin n_err++; $display("FAIL reset_start got %b want 0", enc_start); end
    n_vec++; if (grant_id !== 3'd0) begin n_err++; $display("FAIL reset_grant got %0d want 0", grant_id); end
    n_vec++; if (rsp_frame !== '0) begin n_err++; $display("FAIL reset_frame got %h want 0", rsp_frame); end
    n_vec++; if ({rsp_error, rsp_timeout} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {rsp_error, rsp_timeout}); end
    n_vec++; if ({enc_cmd_select, enc_status} !== 17'd0) begin n_err++; $display("FAIL reset_enc got %h want 0", {enc_cmd_select, enc_status}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [DW-1:0] d;
    d = rand_data();
    mode = 0; k_lat = 3;
    run_one(0, 16'h0001, 1'b1, d);
    n_vec++; if (obs_ack !== 4'b0001) begin n_err++; $display("FAIL basic_ack got %b want 0001", obs_ack); end
    n_vec++; if (obs_starts !== 1) begin n_err++; $display("FAIL basic_starts got %0d want 1", obs_starts); end
    n_vec++; if (obs_scyc !== 0) begin n_err++; $display("FAIL basic_req2start got %0d want 0", obs_scyc); end
    n_vec++; if (obs_lat !== 4) begin n_err++; $display("FAIL basic_latency got %0d want 4", obs_lat); end
    n_vec++; if (rsp_frame[7:0] !== 8'h02) begin n_err++; $display("FAIL basic_byte0 got %h want 02", rsp_frame[7:0]); end
    n_vec++; if (rsp_frame !== exp_frame(16'h0001, 1'b1, d)) begin n_err++; $display("FAIL basic_frame got %h want %h", rsp_frame, exp_frame(16'h0001, 1'b1, d)); end
    n_vec++; if ({rsp_error, rsp_timeout} !== 2'b00) begin n_err++; $display("FAIL basic_flags got %b want 00", {rsp_error, rsp_timeout}); end
    n_vec++; if (grant_id !== 3'd0) begin n_err++; $display("FAIL basic_grant got %0d want 0", grant_id); end
    @(negedge clk);
    n_vec++; if (ack !== '0) begin n_err++; $display("FAIL basic_ack_pulse got %b want 0", ack); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_random_txn();
    for (int it = 0; it < 12; it++) begin
      int idx;
      logic [15:0] c;
      logic s;
      logic [DW-1:0] d;
      idx = $urandom_range(0, N-1);
      c = ($urandom_range(0, 4) == 0) ? 16'h00FF : 16'($urandom_range(1, 16));
      s = 1'($urandom_range(0, 1));
      d = rand_data();
      k_lat = $urandom_range(2, 8);
      run_one(idx, c, s, d);
      n_vec++; if (obs_ack !== onehot(idx)) begin n_err++; $display("FAIL rnd_ack got %b want %b", obs_ack, onehot(idx)); end
      n_vec++; if (obs_lat !== k_lat + 1) begin n_err++; $display("FAIL rnd_latency got %0d want %0d", obs_lat, k_lat + 1); end
      n_vec++; if (rsp_frame !== exp_frame(c, s, d)) begin n_err++; $display("FAIL rnd_frame got %h want %h", rsp_frame, exp_frame(c, s, d)); end
      n_vec++; if ({rsp_error, rsp_timeout} !== {bad_cmd(c), 1'b0}) begin n_err++; $display("FAIL rnd_flags got %b want %b", {rsp_error, rsp_timeout}, {bad_cmd(c), 1'b0}); end
      @(negedge clk);
    end
  endtask

  task automatic test_enc_error();
    logic [DW-1:0] d;
    d = rand_data();
    k_lat = 4;
    run_one(2, 16'h00FF, 1'b1, d);
    n_vec++; if (obs_ack !== 4'b0100) begin n_err++; $display("FAIL err_ack got %b want 0100", obs_ack); end
    n_vec++; if ({rsp_error, rsp_timeout} !== 2'b10) begin n_err++; $display("FAIL err_flags got %b want 10", {rsp_error, rsp_timeout}); end
    n_vec++; if (grant_id !== 3'd2) begin n_err++; $display("FAIL err_grant got %0d want 2", grant_id); end
    @(negedge clk);
  endtask

  task automatic test_timeout_busy();
    logic [FW-1:0] prev;
    logic [DW-1:0] d;
    prev = rsp_frame;
    d = rand_data();
    mode = 1;
    run_one(1, 16'h0003, 1'b1, d);
    n_vec++; if (obs_ack !== 4'b0010) begin n_err++; $display("FAIL tob_ack got %b want 0010", obs_ack); end
    n_vec++; if (obs_lat !== T + 1) begin n_err++; $display("FAIL tob_latency got %0d want %0d", obs_lat, T + 1); end
    n_vec++; if ({rsp_error, rsp_timeout} !== 2'b11) begin n_err++; $display("FAIL tob_flags got %b want 11", {rsp_error, rsp_timeout}); end
    n_vec++; if (rsp_frame !== prev) begin n_err++; $display("FAIL tob_frame_held got %h want %h", rsp_frame, prev); end
    @(negedge clk);
    mode = 0; k_lat = 5;
    d = rand_data();
    run_one(3, 16'h0007, 1'b0, d);
    n_vec++; if (obs_ack !== 4'b1000) begin n_err++; $display("FAIL tob_next_ack got %b want 1000", obs_ack); end
    n_vec++; if ({rsp_error, rsp_timeout} !== 2'b00) begin n_err++; $display("FAIL tob_next_flags got %b want 00", {rsp_error, rsp_timeout}); end
    n_vec++; if (rsp_frame !== exp_frame(16'h0007, 1'b0, d)) begin n_err++; $display("FAIL tob_next_frame got %h want %h", rsp_frame, exp_frame(16'h0007, 1'b0, d)); end
    @(negedge clk);
  endtask

  task automatic test_timeout_done();
    logic [FW-1:0] prev;
    prev = rsp_frame;
    mode = 2;
    run_one(0, 16'h0002, 1'b1, rand_data());
    n_vec++; if (obs_ack !== 4'b0001) begin n_err++; $display("FAIL tod_ack got %b want 0001", obs_ack); end
    n_vec++; if (obs_lat !== T + 2) begin n_err++; $display("FAIL tod_latency got %0d want %0d", obs_lat, T + 2); end
    n_vec++; if ({rsp_error, rsp_timeout} !== 2'b11) begin n_err++; $display("FAIL tod_flags got %b want 11", {rsp_error, rsp_timeout}); end
    n_vec++; if (rsp_frame !== prev) begin n_err++; $display("FAIL tod_frame_held got %h want %h", rsp_frame, prev); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL tod_busy got %b want 0", busy); end
    idle_req++;
    @(negedge clk);
    @(negedge clk);
    mode = 0;
  endtask

  task automatic test_round_robin();
    logic [15:0]   c [N];
    logic          s [N];
    logic [DW-1:0] d [N];
    int exp_g, starts;
    bit got;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      c[i] = 16'($urandom_range(1, 16));
      s[i] = 1'($urandom_range(0, 1));
      d[i] = rand_data();
      set_slot(i, c[i], s[i], d[i]);
    end
    k_lat = 2;
    @(negedge clk);
    req = '1;
    exp_g = 0;
    for (int n = 0; n < 5; n++) begin
      starts = 0; got = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (enc_start) starts++;
        if (|ack) begin got = 1'b1; break; end
      end
      if (n == 4) req = '0;
      n_vec++; if (!got || ack !== onehot(exp_g)) begin n_err++; $display("FAIL rr_ack[%0d] got %b want %b", n, ack, onehot(exp_g)); end
      n_vec++; if (starts !== 1) begin n_err++; $display("FAIL rr_starts[%0d] got %0d want 1", n, starts); end
      n_vec++; if (rsp_frame !== exp_frame(c[exp_g], s[exp_g], d[exp_g])) begin n_err++; $display("FAIL rr_frame[%0d] got %h want %h", n, rsp_frame, exp_frame(c[exp_g], s[exp_g], d[exp_g])); end
      exp_g = (exp_g + 1) % N;
    end
    starts = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (enc_start) starts++;
    end
    n_vec++; if (starts !== 0) begin n_err++; $display("FAIL rr_idle_starts got %0d want 0", starts); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_random_arb();
    logic [N-1:0] mask;
    int last, exp_g;
    bit got;
    last = 0;  // requester 0 was granted last in test_round_robin
    k_lat = 2;
    mask = 4'($urandom_range(1, 15));
    req = mask;
    for (int n = 0; n < 12; n++) begin
      exp_g = -1;
      for (int k = 1; k <= N; k++)
        if (exp_g < 0 && mask[(last + k) % N]) exp_g = (last + k) % N;
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (|ack) begin got = 1'b1; break; end
      end
      n_vec++; if (!got || ack !== onehot(exp_g)) begin n_err++; $display("FAIL arb_ack[%0d] got %b want %b", n, ack, onehot(exp_g)); end
      last = exp_g;
      mask = (mask & ~onehot(exp_g)) | 4'($urandom_range(0, 15));
      if (mask == '0) mask = 4'($urandom_range(1, 15));
      req = mask;
    end
    req = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    bit got;
    d = rand_data();
    mode = 0; k_lat = 20;
    set_slot(1, 16'h0005, 1'b1, d);
    req[1] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (enc_start) begin got = 1'b1; break; end
    end
    n_vec++; if (!got) begin n_err++; $display("FAIL rst_mid_start got 0 want 1"); end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++; if (ack !== '0 || busy !== 1'b0 || enc_start !== 1'b0) begin n_err++; $display("FAIL rst_mid_ctrl got %b%b%b want 0", ack, busy, enc_start); end
    n_vec++; if (grant_id !== 3'd0 || {rsp_error, rsp_timeout} !== 2'b00) begin n_err++; $display("FAIL rst_mid_status got %0d %b want 0 00", grant_id, {rsp_error, rsp_timeout}); end
    n_vec++; if (rsp_frame !== '0 || enc_data !== '0) begin n_err++; $display("FAIL rst_mid_data got %h want 0", rsp_frame); end
    @(negedge clk);
    reset = 1'b0;
    run_one(1, 16'h0005, 1'b1, d);
    n_vec++; if (obs_ack !== 4'b0010) begin n_err++; $display("FAIL rst_mid_ack got %b want 0010", obs_ack); end
    n_vec++; if (obs_lat !== k_lat + 1) begin n_err++; $display("FAIL rst_mid_latency got %0d want %0d", obs_lat, k_lat + 1); end
    n_vec++; if (grant_id !== 3'd1 || {rsp_error, rsp_timeout} !== 2'b00) begin n_err++; $display("FAIL rst_mid_result got %0d %b want 1 00", grant_id, {rsp_error, rsp_timeout}); end
    n_vec++; if (rsp_frame !== exp_frame(16'h0005, 1'b1, d)) begin n_err++; $display("FAIL rst_mid_frame got %h want %h", rsp_frame, exp_frame(16'h0005, 1'b1, d)); end
    @(negedge clk);
  endtask

  initial begin
    req = '0;
    req_cmd_select = '0;
    req_status = '0;
    req_data = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_random_txn();
    test_enc_error();
    test_timeout_busy();
    test_timeout_done();
    test_round_robin();
    test_random_arb();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/host_rsp_encode_arbiter.md
Name: host_rsp_encode_arbiter

Overview:
Shares one host UART response encoder between NUM_REQ requesters, e.g. the encryption-control and yaw-sensor handlers. Requests are granted round-robin. For each grant the block drives the encoder's start/cmd_select/status/data inputs and tracks its done/error handshake with a timeout. It returns the finished response frame, plus a status, to the granted requester. It sits between the command handlers and the response encoder.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 264, payload width per requester and to the encoder
FRAME_W, 1025, encoder output frame width
TIMEOUT_CYCLES, 64, maximum cycles to wait in each encoder wait phase

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
req  input  NUM_REQ  level request per requester, held until its ack
req_cmd_select  input  16*NUM_REQ  response type per requester; slot i = bits [16i+15:16i]
req_status  input  NUM_REQ  success(1)/fail(0) per requester
req_data  input  DATA_W*NUM_REQ  payload per requester; slot i = bits [DATA_W*i+DATA_W-1:DATA_W*i]
ack  output  NUM_REQ  one-cycle one-hot completion pulse
rsp_frame  output  FRAME_W  captured encoder frame; valid in the ack cycle and held until the next completion
rsp_error  output  1  valid with ack: encoder error or timeout
rsp_timeout  output  1  valid with ack: timeout cause
grant_id  output  3  index of current/last granted requester
busy  output  1  high in any state other than IDLE
enc_start  output  1  encoder start pulse
enc_cmd_select  output  16  to encoder
enc_status  output  1  to encoder
enc_data  output  DATA_W  to encoder
enc_frame  input  FRAME_W  from encoder
enc_done  input  1  encoder idle/complete (high when idle)
enc_error  input  1  encoder unknown-command flag

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0. rr_ptr=NUM_REQ-1, so requester 0 has first priority. Timeout counter cleared. Reset mid-transaction abandons the request with no ack; the requester's req stays high and is re-arbitrated after reset.
- IDLE: if any req bit is set and enc_done=1, grant the first set bit searching from rr_ptr+1 with wrap-around. Latch that requester's cmd_select/status/data into enc_* registers, set grant_id, go to ISSUE. If enc_done=0, stay in IDLE (encoder busy elsewhere).
- ISSUE (1 cycle): enc_start=1, timeout counter cleared, go to WAIT_BUSY. enc_* inputs stay stable from ISSUE through RESP.
- WAIT_BUSY: wait for enc_done=0 (encoder accepted).
  - On enc_done=0, clear the counter and go to WAIT_DONE.
  - Same-cycle completion is not supported; the encoder always drops done for at least one cycle.
- WAIT_DONE: wait for enc_done=1.
  - Then capture rsp_frame<=enc_frame, rsp_error<=enc_error, rsp_timeout<=0, and go to RESP.
- Timeout: in WAIT_BUSY or WAIT_DONE, the counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 without the awaited edge, go to RESP with rsp_error=1, rsp_timeout=1, and rsp_frame unchanged.
- RESP (1 cycle): ack[grant_id]=1, rr_ptr<=grant_id, enc_start=0, go to IDLE.
- Requester rule: drop req in the cycle after ack. A req still high in the cycle after ack is treated as a new request, subject to round-robin.
- req deasserting mid-transaction is ignored; the transaction completes and ack still pulses.
- Simultaneous requests: strict rotation. With all bits held, the grant order is 0,1,2,3,0,…
- Latency, idle encoder with done dropping the cycle after start and rising K cycles later: req→enc_start = 1 cycle (IDLE registers the grant); enc_done rise → ack = 1 cycle.
- Error from the encoder (unknown cmd_select) is passed through as rsp_error=1, rsp_timeout=0.

Test Plan:
- Reset, then req[0]=1 with cmd=0x0001, status=1; behavioural encoder model returns frame byte0=0x02 → enc_start pulses once, ack[0] pulses once, rsp_frame[7:0]=0x02, rsp_error=0, grant_id=0.
- req=4'b1111 held, re-raised after each ack → grants in order 0,1,2,3,0. Exactly one ack per transaction; enc_start never asserted while busy.
- req[2]=1 with cmd=0x00FF; model asserts enc_error → ack[2] with rsp_error=1, rsp_timeout=0.
- Model never drops enc_done after start → ack at ISSUE+TIMEOUT_CYCLES+1 with rsp_error=1, rsp_timeout=1; a following request succeeds.
- Model drops done but never raises it → timeout in WAIT_DONE, same flags as the previous case; busy=0 after RESP.
- Assert reset in WAIT_DONE → all outputs 0 immediately; after release, the held req[1] is re-granted and completes normally.
